// File: rtl/riscv_writeback_pkg.sv
// Shared types and constants for the RV32I writeback stage: result-source encoding,
// byte-lane masks and the packed W pipeline register.
package riscv_writeback_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RES_SRC_ALU = 2'b00,
    RES_SRC_MEM = 2'b01,
    RES_SRC_PC4 = 2'b10,
    RES_SRC_IMM = 2'b11
  } result_src_e;

  localparam logic [3:0] BSEL_B0 = 4'b0001;
  localparam logic [3:0] BSEL_B1 = 4'b0010;
  localparam logic [3:0] BSEL_B2 = 4'b0100;
  localparam logic [3:0] BSEL_B3 = 4'b1000;
  localparam logic [3:0] BSEL_H0 = 4'b0011;
  localparam logic [3:0] BSEL_H1 = 4'b1100;
  localparam logic [3:0] BSEL_W  = 4'b1111;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    result_src_e       result_src;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   read_data;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   extimm;
    logic [4:0]        rd;
    logic [3:0]        byte_sel;
    logic              is_unsigned;
  } w_regs_t;

endpackage

// File: rtl/riscv_writeback_load_ext.sv
// Load-data extractor: picks the byte/halfword/word lane out of the aligned memory word
// and sign- or zero-extends it. Unsupported masks yield zero.
module riscv_load_ext
  import riscv_writeback_pkg::*;
(
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_offset,
  input  logic [3:0]      i_byte_sel,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = i_word[{i_offset, 3'b000} +: 8];
    half_val = i_offset[1] ? i_word[31:16] : i_word[15:0];
    o_data   = '0;
    case (i_byte_sel)
      BSEL_B0, BSEL_B1, BSEL_B2, BSEL_B3:
        o_data = i_unsigned ? {{(XLEN-8){1'b0}}, byte_val}
                            : {{(XLEN-8){byte_val[7]}}, byte_val};
      BSEL_H0, BSEL_H1:
        o_data = i_unsigned ? {{(XLEN-16){1'b0}}, half_val}
                            : {{(XLEN-16){half_val[15]}}, half_val};
      BSEL_W:
        o_data = i_word;
      default:
        o_data = '0;
    endcase
  end

endmodule

// File: rtl/riscv_writeback.sv
// RV32I M->W pipeline register and writeback result selection.
// Optional retired-instruction counter (o_instret) enabled by defining RISCV_WB_INSTRET_EN.
module riscv_writeback
  import riscv_writeback_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_stall_w,
  input  logic            i_flush_w,
  input  logic            i_valid_m,
  input  logic            i_reg_write_m,
  input  logic [1:0]      i_result_src_m,
  input  logic [XLEN-1:0] i_alu_result_m,
  input  logic [XLEN-1:0] i_read_data_m,
  input  logic [XLEN-1:0] i_pc_plus4_m,
  input  logic [XLEN-1:0] i_extimm_m,
  input  logic [4:0]      i_rd_m,
  input  logic [3:0]      i_mem_byte_sel_m,
  input  logic            i_unsigned_m,
  output logic [XLEN-1:0] o_result_w,
  output logic            o_reg_write_w,
  output logic [4:0]      o_rd_w,
  output logic            o_valid_w
`ifdef RISCV_WB_INSTRET_EN
  ,
  output logic [63:0]     o_instret
`endif
);

  w_regs_t         w_q, w_d;
  logic [XLEN-1:0] load_data;

  // Flush beats stall; a flushed W keeps its data fields and only drops the control bits.
  always_comb begin
    w_d = w_q;
    if (i_flush_w) begin
      w_d.valid     = 1'b0;
      w_d.reg_write = 1'b0;
    end else if (!i_stall_w) begin
      w_d.valid       = i_valid_m;
      w_d.reg_write   = i_reg_write_m;
      w_d.result_src  = result_src_e'(i_result_src_m);
      w_d.alu_result  = i_alu_result_m;
      w_d.read_data   = i_read_data_m;
      w_d.pc_plus4    = i_pc_plus4_m;
      w_d.extimm      = i_extimm_m;
      w_d.rd          = i_rd_m;
      w_d.byte_sel    = i_mem_byte_sel_m;
      w_d.is_unsigned = i_unsigned_m;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) w_q <= '0;
    else         w_q <= w_d;
  end

  riscv_load_ext u_load_ext (
    .i_word     (w_q.read_data),
    .i_offset   (w_q.alu_result[1:0]),
    .i_byte_sel (w_q.byte_sel),
    .i_unsigned (w_q.is_unsigned),
    .o_data     (load_data)
  );

  always_comb begin
    o_result_w = w_q.alu_result;
    case (w_q.result_src)
      RES_SRC_ALU: o_result_w = w_q.alu_result;
      RES_SRC_MEM: o_result_w = load_data;
      RES_SRC_PC4: o_result_w = w_q.pc_plus4;
      RES_SRC_IMM: o_result_w = w_q.extimm;
      default:     o_result_w = w_q.alu_result;
    endcase
  end

  // x0 is hardwired zero, so a write to it is never presented to the regfile.
  assign o_reg_write_w = w_q.valid & w_q.reg_write & (w_q.rd != 5'd0);
  assign o_rd_w        = w_q.rd;
  assign o_valid_w     = w_q.valid;

`ifdef RISCV_WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (w_q.valid && !i_stall_w) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) instret_q <= '0;
    else         instret_q <= instret_d;
  end

  assign o_instret = instret_q;
`endif

endmodule

// File: tb/tb_riscv_writeback.sv
// Directed scoreboard bench for riscv_writeback: expected W outputs are queued as each
// step is driven and popped/checked one cycle later.
module tb_riscv_writeback;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_stall_w, i_flush_w, i_valid_m, i_reg_write_m, i_unsigned_m;
  logic [1:0]  i_result_src_m;
  logic [31:0] i_alu_result_m, i_read_data_m, i_pc_plus4_m, i_extimm_m;
  logic [4:0]  i_rd_m;
  logic [3:0]  i_mem_byte_sel_m;
  logic [31:0] o_result_w;
  logic        o_reg_write_w, o_valid_w;
  logic [4:0]  o_rd_w;
`ifdef RISCV_WB_INSTRET_EN
  logic [63:0] o_instret;
  longint unsigned expInstret = 0;
`endif

  typedef struct packed {
    logic [31:0] result;
    logic        regWrite;
    logic [4:0]  rd;
    logic        valid;
  } exp_t;

  exp_t expQ[$];
  exp_t lastExp;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 i_clk = ~i_clk;

  riscv_writeback dut (
    .i_clk            (i_clk),
    .i_rstn           (i_rstn),
    .i_stall_w        (i_stall_w),
    .i_flush_w        (i_flush_w),
    .i_valid_m        (i_valid_m),
    .i_reg_write_m    (i_reg_write_m),
    .i_result_src_m   (i_result_src_m),
    .i_alu_result_m   (i_alu_result_m),
    .i_read_data_m    (i_read_data_m),
    .i_pc_plus4_m     (i_pc_plus4_m),
    .i_extimm_m       (i_extimm_m),
    .i_rd_m           (i_rd_m),
    .i_mem_byte_sel_m (i_mem_byte_sel_m),
    .i_unsigned_m     (i_unsigned_m),
    .o_result_w       (o_result_w),
    .o_reg_write_w    (o_reg_write_w),
    .o_rd_w           (o_rd_w),
    .o_valid_w        (o_valid_w)
`ifdef RISCV_WB_INSTRET_EN
    ,
    .o_instret        (o_instret)
`endif
  );

  function automatic exp_t mkExp(input logic [31:0] result, input logic regWrite,
                                 input logic [4:0] rd, input logic valid);
    exp_t e;
    e.result   = result;
    e.regWrite = regWrite;
    e.rd       = rd;
    e.valid    = valid;
    return e;
  endfunction

  task automatic setInputs(input logic valid, input logic rw, input logic [1:0] src,
                           input logic [31:0] alu, input logic [31:0] rdata,
                           input logic [31:0] pc4, input logic [31:0] imm,
                           input logic [4:0] rd, input logic [3:0] sel, input logic uns);
    i_valid_m        = valid;
    i_reg_write_m    = rw;
    i_result_src_m   = src;
    i_alu_result_m   = alu;
    i_read_data_m    = rdata;
    i_pc_plus4_m     = pc4;
    i_extimm_m       = imm;
    i_rd_m           = rd;
    i_mem_byte_sel_m = sel;
    i_unsigned_m     = uns;
  endtask

  // Pop one expectation and compare every W output against it.
  task automatic checkOutput(input string tag);
    exp_t e;
    vectors++;
    assert (expQ.size() != 0) else begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed outputs with nothing expected", tag);
    end
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      vectors++;
      assert (o_result_w === e.result) else begin
        miscompares++;
        $error("FAIL %s.result: observed %h expected %h", tag, o_result_w, e.result);
      end
      vectors++;
      assert (o_reg_write_w === e.regWrite) else begin
        miscompares++;
        $error("FAIL %s.reg_write: observed %b expected %b", tag, o_reg_write_w, e.regWrite);
      end
      vectors++;
      assert (o_rd_w === e.rd) else begin
        miscompares++;
        $error("FAIL %s.rd: observed %0d expected %0d", tag, o_rd_w, e.rd);
      end
      vectors++;
      assert (o_valid_w === e.valid) else begin
        miscompares++;
        $error("FAIL %s.valid: observed %b expected %b", tag, o_valid_w, e.valid);
      end
    end
`ifdef RISCV_WB_INSTRET_EN
    vectors++;
    assert (o_instret === expInstret) else begin
      miscompares++;
      $error("FAIL %s.instret: observed %0d expected %0d", tag, o_instret, expInstret);
    end
`endif
  endtask

  // Queue the expectation, clock one edge, then check just after it.
  task automatic applyStimulus(input string tag, input logic stall, input logic flush,
                               input exp_t e);
    i_stall_w = stall;
    i_flush_w = flush;
`ifdef RISCV_WB_INSTRET_EN
    if (lastExp.valid && !stall) expInstret++;
`endif
    expQ.push_back(e);
    lastExp = e;
    @(posedge i_clk);
    #1;
    checkOutput(tag);
  endtask

  exp_t heldExp;

  initial begin
    i_rstn    = 1'b0;
    i_stall_w = 1'b0;
    i_flush_w = 1'b0;
    setInputs(1, 1, 2'b00, 32'h1, 32'h0, 32'h0, 32'h0, 5'd1, 4'b1111, 0);
    lastExp = mkExp(32'h0, 0, 5'd0, 0);
    repeat (2) @(posedge i_clk);
    #1;
    expQ.push_back(lastExp);
    checkOutput("reset");
    i_rstn = 1'b1;

    // Load extraction cases
    setInputs(1, 1, 2'b01, 32'h2, 32'h80FF_7F01, 32'h0, 32'h0, 5'd3, 4'b0100, 0);
    applyStimulus("lb_signed", 0, 0, mkExp(32'hFFFF_FFFF, 1, 5'd3, 1));
    setInputs(1, 1, 2'b01, 32'h2, 32'h80FF_7F01, 32'h0, 32'h0, 5'd3, 4'b0100, 1);
    applyStimulus("lbu", 0, 0, mkExp(32'h0000_00FF, 1, 5'd3, 1));
    setInputs(1, 1, 2'b01, 32'h1, 32'h80FF_7F01, 32'h0, 32'h0, 5'd6, 4'b0010, 0);
    applyStimulus("lb_lane1", 0, 0, mkExp(32'h0000_007F, 1, 5'd6, 1));
    setInputs(1, 1, 2'b01, 32'h2, 32'h8001_1234, 32'h0, 32'h0, 5'd4, 4'b1100, 0);
    applyStimulus("lh_signed", 0, 0, mkExp(32'hFFFF_8001, 1, 5'd4, 1));
    setInputs(1, 1, 2'b01, 32'h0, 32'h8001_1234, 32'h0, 32'h0, 5'd4, 4'b1111, 0);
    applyStimulus("lw", 0, 0, mkExp(32'h8001_1234, 1, 5'd4, 1));
    setInputs(1, 1, 2'b01, 32'h0, 32'h8001_9234, 32'h0, 32'h0, 5'd8, 4'b0011, 1);
    applyStimulus("lhu_lane0", 0, 0, mkExp(32'h0000_9234, 1, 5'd8, 1));
    setInputs(1, 1, 2'b01, 32'h0, 32'h8001_9234, 32'h0, 32'h0, 5'd8, 4'b0101, 0);
    applyStimulus("bad_mask", 0, 0, mkExp(32'h0, 1, 5'd8, 1));

    // Result mux and x0 qualification
    setInputs(1, 1, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 5'd0, 4'b1111, 0);
    applyStimulus("alu_x0", 0, 0, mkExp(32'h1234_5678, 0, 5'd0, 1));
    setInputs(1, 1, 2'b00, 32'hCAFE_BABE, 32'h0, 32'h0, 32'h0, 5'd5, 4'b1111, 0);
    applyStimulus("alu_x5", 0, 0, mkExp(32'hCAFE_BABE, 1, 5'd5, 1));
    setInputs(1, 1, 2'b10, 32'h5, 32'h0, 32'h0000_1004, 32'h0, 5'd1, 4'b1111, 0);
    applyStimulus("pc4", 0, 0, mkExp(32'h0000_1004, 1, 5'd1, 1));
    setInputs(1, 1, 2'b11, 32'h5, 32'h0, 32'h0, 32'hABCD_E000, 5'd2, 4'b1111, 0);
    applyStimulus("imm", 0, 0, mkExp(32'hABCD_E000, 1, 5'd2, 1));
    setInputs(0, 1, 2'b00, 32'h7777_0000, 32'h0, 32'h0, 32'h0, 5'd7, 4'b1111, 0);
    applyStimulus("invalid", 0, 0, mkExp(32'h7777_0000, 0, 5'd7, 0));

    // Stall three cycles, then flush+stall together
    setInputs(1, 1, 2'b00, 32'h1111_1111, 32'h0, 32'h0, 32'h0, 5'd9, 4'b1111, 0);
    heldExp = mkExp(32'h1111_1111, 1, 5'd9, 1);
    applyStimulus("pre_stall", 0, 0, heldExp);
    setInputs(1, 1, 2'b00, 32'h2222_2222, 32'h0, 32'h0, 32'h0, 5'd10, 4'b1111, 0);
    for (int i = 0; i < 3; i++) applyStimulus("stall", 1, 0, heldExp);
    applyStimulus("flush_stall", 1, 1, mkExp(32'h1111_1111, 0, 5'd9, 0));
    applyStimulus("post_flush", 0, 0, mkExp(32'h2222_2222, 1, 5'd10, 1));
    applyStimulus("flush_only", 0, 1, mkExp(32'h2222_2222, 0, 5'd10, 0));

    // Several back-to-back retirements
    for (int i = 1; i <= 4; i++) begin
      setInputs(1, 1, 2'b00, 32'h100 + i, 32'h0, 32'h0, 32'h0, 5'(10 + i), 4'b1111, 0);
      applyStimulus("stream", 0, 0, mkExp(32'h100 + i, 1, 5'(10 + i), 1));
    end

    // Asynchronous reset in the middle of a cycle while W is valid
    #2;
    i_rstn = 1'b0;
    #1;
    lastExp = mkExp(32'h0, 0, 5'd0, 0);
`ifdef RISCV_WB_INSTRET_EN
    expInstret = 0;
`endif
    expQ.push_back(lastExp);
    checkOutput("async_reset");
    @(posedge i_clk);
    #1;
    expQ.push_back(lastExp);
    checkOutput("reset_held");
    i_rstn = 1'b1;
    setInputs(1, 1, 2'b00, 32'hBEEF_0001, 32'h0, 32'h0, 32'h0, 5'd31, 4'b1111, 0);
    applyStimulus("after_reset", 0, 0, mkExp(32'hBEEF_0001, 1, 5'd31, 1));
    setInputs(0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'b0000, 0);
    applyStimulus("drain", 0, 0, mkExp(32'h0, 0, 5'd0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
